// File: rtl/multicycle_core.sv
// Multicycle 16-bit-instruction core: FETCH/DECODE/EXECUTE/WRITEBACK/HALT over an 8-entry register file.
// Optional: define MULTICYCLE_CORE_ZERO_REG_EN to hard-wire r0 to zero.
module multicycle_core #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PC_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic              wb_en,
    output logic [2:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data
);

    localparam int unsigned NUM_REGS = 8;

`ifdef MULTICYCLE_CORE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_SUBI = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t            state;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    logic [2:0]        op;
    logic [2:0]        rd;
    logic [2:0]        rs;
    logic [2:0]        rt;
    logic [3:0]        imm4;
    logic [15:0]       imm7_ext;
    logic [DATA_W-1:0] alu_c;
    logic [PC_W-1:0]   pc_inc_c;
    logic [PC_W-1:0]   br_target_c;

    always_comb begin
        op       = ir[15:13];
        rd       = ir[12:10];
        rs       = ir[9:7];
        rt       = ir[2:0];
        imm4     = ir[3:0];
        imm7_ext = {{9{ir[6]}}, ir[6:0]};
    end

    assign imem_addr   = pc;
    assign pc_inc_c    = pc + PC_W'(1);
    // Sign-extended offset truncated to PC_W gives modulo-2^PC_W branch arithmetic.
    assign br_target_c = pc_inc_c + PC_W'(imm7_ext);

    always_comb begin
        alu_c = '0;
        case (op)
            OP_ADD:  alu_c = op_a + op_b;
            OP_SUB:  alu_c = op_a - op_b;
            OP_ADDI: alu_c = op_a + DATA_W'(imm4);
            OP_SUBI: alu_c = op_a - DATA_W'(imm4);
            default: alu_c = '0;
        endcase
    end

    function automatic logic [DATA_W-1:0] read_reg(input logic [2:0] idx);
        if (ZERO_REG && (idx == 3'd0)) begin
            return '0;
        end
        return regs[idx];
    endfunction

    // Control FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            pc       <= '0;
            ir       <= '0;
            op_a     <= '0;
            op_b     <= '0;
            imem_req <= 1'b1;
            halted   <= 1'b0;
            wb_en    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wb_en <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_data;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_a  <= read_reg(rs);
                    op_b  <= (op == OP_BEQ) ? read_reg(rd) : read_reg(rt);
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: begin
                            wb_en   <= 1'b1;
                            wb_addr <= rd;
                            wb_data <= alu_c;
                            state   <= S_WRITEBACK;
                        end
                        OP_BEQ: begin
                            pc       <= (op_a == op_b) ? br_target_c : pc_inc_c;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: begin
                            pc       <= pc_inc_c;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    endcase
                end
                S_WRITEBACK: begin
                    // Commit happens on leaving WRITEBACK so a reset during it aborts the write.
                    if (!(ZERO_REG && (wb_addr == 3'd0))) begin
                        regs[wb_addr] <= wb_data;
                    end
                    pc       <= pc_inc_c;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: directed programs plus random programs against an ISA-level model.
module tb_multicycle_core;

    localparam int unsigned DW   = 8;
    localparam int unsigned PW   = 10;
    localparam int          PCN  = 1 << PW;
    localparam int          MASK = (1 << DW) - 1;
    localparam logic [15:0] HALT_W = 16'hE000;

`ifdef MULTICYCLE_CORE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [15:0]   imem_data;
    logic [PW-1:0] pc;
    logic          halted;
    logic          wb_en;
    logic [2:0]    wb_addr;
    logic [DW-1:0] wb_data;

    logic [15:0] mem [PCN];

    int total = 0;
    int bad   = 0;

    int exp_wa[$];
    int exp_wd[$];
    int exp_pc;
    int exp_cycles;

    multicycle_core #(.DATA_W(DW), .PC_W(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .pc        (pc),
        .halted    (halted),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int lo7);
        logic [15:0] w;
        w = {3'(op), 3'(rd), 3'(rs), 7'(lo7)};
        return w;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < PCN; i++) mem[i] = HALT_W;
    endtask

    // Instruction-level interpreter: produces expected writes, final pc and ack-free cycle count.
    task automatic model_run();
        int r [8];
        int p, steps, op, rd, rs, rt, i4, i7, a, b, v;
        logic [15:0] w;
        bit stop;
        for (int i = 0; i < 8; i++) r[i] = 0;
        exp_wa.delete();
        exp_wd.delete();
        p = 0; exp_cycles = 0; steps = 0; stop = 0;
        while (!stop && steps < 500) begin
            w  = mem[p];
            op = int'(w[15:13]); rd = int'(w[12:10]); rs = int'(w[9:7]);
            rt = int'(w[2:0]);   i4 = int'(w[3:0]);   i7 = int'(w[6:0]);
            if (i7 >= 64) i7 -= 128;
            a = (ZERO_REG && rs == 0) ? 0 : r[rs];
            steps++;
            if (op <= 3) begin
                b = (ZERO_REG && rt == 0) ? 0 : r[rt];
                case (op)
                    0: v = a + b;
                    1: v = a - b;
                    2: v = a + i4;
                    default: v = a - i4;
                endcase
                v = v & MASK;
                exp_wa.push_back(rd);
                exp_wd.push_back(v);
                if (!(ZERO_REG && rd == 0)) r[rd] = v;
                p = (p + 1) % PCN;
                exp_cycles += 4;
            end else if (op == 4) begin
                b = (ZERO_REG && rd == 0) ? 0 : r[rd];
                p = (a == b) ? (((p + 1 + i7) % PCN) + PCN) % PCN : (p + 1) % PCN;
                exp_cycles += 3;
            end else if (op == 7) begin
                exp_cycles += 3;
                stop = 1;
            end else begin
                p = (p + 1) % PCN;
                exp_cycles += 3;
            end
        end
        exp_pc = p;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check("rst_imem_req", imem_req, 1);
        check("rst_pc", pc, 0);
        check("rst_halted", halted, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs from the current negedge until HALT; ack_mode 0 = always ack, 1 = random; first `stall` fetch cycles are refused.
    task automatic run_loop(input string name, input int ack_mode, input int stall);
        int cycles, waits, stall_left;
        bit done, prev_wait;
        logic [PW-1:0] prev_addr;
        cycles = 0; waits = 0; done = 0; prev_wait = 0; prev_addr = '0;
        stall_left = stall;
        for (int it = 0; it < 4000 && !done; it++) begin
            if (halted) begin
                done = 1;
            end else begin
                cycles++;
                if (imem_req) begin
                    if (stall_left > 0) begin
                        imem_ack = 1'b0;
                        stall_left--;
                    end else begin
                        imem_ack = (ack_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
                    end
                    if (prev_wait) check({name, "_addr_stable"}, imem_addr, prev_addr);
                    if (!imem_ack) waits++;
                    prev_wait = !imem_ack;
                    prev_addr = imem_addr;
                end else begin
                    imem_ack  = 1'($urandom_range(0, 1));
                    prev_wait = 0;
                end
                if (wb_en) begin
                    if (exp_wa.size() == 0) begin
                        check({name, "_wb_extra"}, 1, 0);
                    end else begin
                        check({name, "_wb_addr"}, wb_addr, exp_wa.pop_front());
                        check({name, "_wb_data"}, wb_data, exp_wd.pop_front());
                    end
                end
                @(negedge clk);
            end
        end
        check({name, "_halt_reached"}, done, 1);
        check({name, "_halt_pc"}, pc, exp_pc);
        check({name, "_cycles"}, cycles, exp_cycles + waits);
        check({name, "_wb_missing"}, exp_wa.size(), 0);
        for (int k = 0; k < 3; k++) begin
            imem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            check({name, "_halt_hold"}, {halted, imem_req, wb_en}, 3'b100);
            check({name, "_halt_pc_hold"}, pc, exp_pc);
        end
    endtask

    task automatic run_program(input string name, input int ack_mode, input int stall);
        model_run();
        apply_reset();
        run_loop(name, ack_mode, stall);
    endtask

    initial begin
        @(negedge clk);

        // Basic program, ack tied high
        clear_mem();
        mem[0] = enc(2, 1, 0, 5);
        mem[1] = enc(2, 2, 0, 3);
        mem[2] = enc(0, 3, 1, 2);
        run_program("basic", 0, 0);

        // Same program with the first fetch stalled 5 cycles
        run_program("stall5", 0, 5);

        // 8-bit wrap: 16x ADDI r1,r1,15 -> 240, then 255, then 14
        clear_mem();
        for (int i = 0; i < 18; i++) mem[i] = enc(2, 1, 1, 15);
        run_program("wrap", 0, 0);

        // Tight branch loop at address 4 returns every 3 cycles
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = enc(5, 0, 0, 0);
        mem[4] = enc(4, 0, 0, 7'h7F);
        apply_reset();
        for (int it = 0; it < 24; it++) begin
            imem_ack = 1'b1;
            if (it >= 12 && (it % 3) == 0) begin
                check("beq_loop_req", imem_req, 1);
                check("beq_loop_addr", imem_addr, 4);
            end else if (it >= 12) begin
                check("beq_loop_noreq", imem_req, 0);
            end
            @(negedge clk);
        end

        // Branch not taken on unequal registers
        clear_mem();
        mem[0] = enc(2, 1, 0, 1);
        for (int i = 1; i < 4; i++) mem[i] = enc(6, 0, 0, 0);
        mem[4] = enc(4, 1, 0, 7'h7F);
        run_program("beq_ne", 0, 0);

        // r0 behaviour depends on the zero-register build option
        clear_mem();
        mem[0] = enc(2, 0, 0, 7);
        mem[1] = enc(0, 1, 0, 0);
        run_program("zero_reg", 0, 0);

        // Reset during WRITEBACK aborts the write
        clear_mem();
        mem[0] = enc(2, 4, 0, 9);
        apply_reset();
        begin
            bit seen;
            seen = 0;
            for (int it = 0; it < 20 && !seen; it++) begin
                imem_ack = 1'b1;
                if (wb_en) seen = 1;
                else @(negedge clk);
            end
            check("rstwb_seen", seen, 1);
            check("rstwb_addr", wb_addr, 4);
        end
        reset = 1'b1;
        #1;
        check("rstwb_wb_en", wb_en, 0);
        check("rstwb_pc", pc, 0);
        mem[0] = enc(0, 6, 4, 4);
        model_run();
        @(negedge clk);
        reset = 1'b0;
        check("rstwb_first_req", imem_req, 1);
        check("rstwb_first_addr", imem_addr, 0);
        run_loop("rstwb", 0, 0);

        // Random programs with forward-only branches and random ack
        for (int n = 0; n < 8; n++) begin
            int sel, lo;
            clear_mem();
            for (int i = 0; i < 20; i++) begin
                sel = $urandom_range(0, 9);
                lo  = $urandom_range(0, 127);
                case (sel)
                    0, 1:    mem[i] = enc(0, $urandom_range(0, 7), $urandom_range(0, 7), lo);
                    2:       mem[i] = enc(1, $urandom_range(0, 7), $urandom_range(0, 7), lo);
                    3, 4:    mem[i] = enc(2, $urandom_range(0, 7), $urandom_range(0, 7), lo);
                    5:       mem[i] = enc(3, $urandom_range(0, 7), $urandom_range(0, 7), lo);
                    6, 7:    mem[i] = enc(4, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
                    default: mem[i] = enc($urandom_range(5, 6), 0, 0, lo);
                endcase
            end
            run_program("random", 1, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
